// File: rtl/placar_pkg.sv
// Shared constants and the debounce state encoding for the scoreboard input side.
package placar_pkg;

    // Key index of each command inside btn_n / cmd
    localparam int unsigned CMD_MAIS1  = 0;
    localparam int unsigned CMD_MAIS2  = 1;
    localparam int unsigned CMD_MAIS3  = 2;
    localparam int unsigned CMD_DESFAZ = 3;

    // Above this value the display needs the hundreds digit
    localparam int unsigned LIMITE_BCD = 99;

    // Debounce states: released, confirming press, pressed, confirming release
    typedef enum logic [1:0] {
        Solto,
        ConfPress,
        Press,
        ConfSolta
    } estado_e;

endpackage

// File: rtl/debounce_botao.sv
// One key: 2-flop synchronizer, debounce FSM and counter. Emits a single-cycle pulse per
// validated press and a debounced level.
module debounce_botao
    import placar_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,    // synchronous, active-low
    input  logic btn_n_i,   // raw, asynchronous, active-low
    output logic pulso_o,
    output logic nivel_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic            sinc1_q, sinc1_d;
    logic            sinc2_q, sinc2_d;
    logic [1:0]      valido_q, valido_d;
    logic            armado_q, armado_d;
    estado_e         estado_q, estado_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fim_cnt;

    assign fim_cnt = (cnt_q == CntW'(DEBOUNCE_CYCLES - 1));

    // State register: synchronizer, pipeline-valid marks, arm flag, FSM and counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sinc1_q  <= 1'b0;
            sinc2_q  <= 1'b0;
            valido_q <= '0;
            armado_q <= 1'b0;
            estado_q <= Solto;
            cnt_q    <= '0;
        end else begin
            sinc1_q  <= sinc1_d;
            sinc2_q  <= sinc2_d;
            valido_q <= valido_d;
            armado_q <= armado_d;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state. A key held through reset must be seen released (with real synchronized
    // data, hence valido_q) before a press can be accepted.
    always_comb begin
        sinc1_d  = ~btn_n_i;
        sinc2_d  = sinc1_q;
        valido_d = {valido_q[0], 1'b1};
        armado_d = armado_q | (valido_q[1] & ~sinc2_q);
        estado_d = estado_q;
        cnt_d    = cnt_q;
        case (estado_q)
            Solto: begin
                if (sinc2_q && armado_q) begin
                    estado_d = ConfPress;
                    cnt_d    = '0;
                end
            end
            ConfPress: begin
                if (!sinc2_q) begin
                    estado_d = Solto;
                end else if (fim_cnt) begin
                    estado_d = Press;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            Press: begin
                if (!sinc2_q) begin
                    estado_d = ConfSolta;
                    cnt_d    = '0;
                end
            end
            ConfSolta: begin
                if (sinc2_q) begin
                    estado_d = Press;
                end else if (fim_cnt) begin
                    estado_d = Solto;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: estado_d = Solto;
        endcase
    end

    // Outputs: pulse on the cycle the press is confirmed, level while debounced-pressed
    always_comb begin
        pulso_o = (estado_q == ConfPress) && sinc2_q && fim_cnt;
        nivel_o = (estado_q == Press) || (estado_q == ConfSolta);
    end

endmodule

// File: rtl/placar_entrada_botoes.sv
// Scoreboard input side: debounces four keys, arbitrates commands and keeps two saturating
// binary scores that feed the display chain.
module placar_entrada_botoes
    import placar_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SCORE_W         = 8,
    parameter int unsigned SCORE_MAX       = 199
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [3:0]         btn_n,
    input  logic               chave_time,
    input  logic               zerar,
    output logic [SCORE_W-1:0] placar_a,
    output logic [SCORE_W-1:0] placar_b,
    output logic               passou99_a,
    output logic               passou99_b,
    output logic               evento
);

    localparam int unsigned SomaW = SCORE_W + 1;

    logic [3:0]         cmd;
    logic               chave_s1_q, chave_s1_d;
    logic               chave_s2_q, chave_s2_d;
    logic [SCORE_W-1:0] placar_a_q, placar_a_d;
    logic [SCORE_W-1:0] placar_b_q, placar_b_d;
    logic               passou99_a_q, passou99_a_d;
    logic               passou99_b_q, passou99_b_d;
    logic               evento_q, evento_d;
    logic [SCORE_W-1:0] base, novo;

    // Add with saturation, one bit wider so the sum cannot wrap
    function automatic logic [SCORE_W-1:0] soma_sat(input logic [SCORE_W-1:0] v,
                                                    input logic [1:0] k);
        logic [SomaW-1:0] s;
        s = {1'b0, v} + SomaW'(k);
        if (s > SomaW'(SCORE_MAX)) begin
            s = SomaW'(SCORE_MAX);
        end
        return s[SCORE_W-1:0];
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_botao
        // Debounced level is not needed here; only the press pulse drives a command
        debounce_botao #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i  (clock),
            .rst_ni (reset_n),
            .btn_n_i(btn_n[i]),
            .pulso_o(cmd[i]),
            .nivel_o()
        );
    end

    // Registers: team-switch synchronizer, scores and their flags
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            chave_s1_q   <= 1'b0;
            chave_s2_q   <= 1'b0;
            placar_a_q   <= '0;
            placar_b_q   <= '0;
            passou99_a_q <= 1'b0;
            passou99_b_q <= 1'b0;
            evento_q     <= 1'b0;
        end else begin
            chave_s1_q   <= chave_s1_d;
            chave_s2_q   <= chave_s2_d;
            placar_a_q   <= placar_a_d;
            placar_b_q   <= placar_b_d;
            passou99_a_q <= passou99_a_d;
            passou99_b_q <= passou99_b_d;
            evento_q     <= evento_d;
        end
    end

    // Next scores: zerar > undo > +3 > +2 > +1, lower-priority pulses dropped
    always_comb begin
        chave_s1_d = chave_time;
        chave_s2_d = chave_s1_q;
        base       = chave_s2_q ? placar_b_q : placar_a_q;
        novo       = base;
        if (cmd[CMD_DESFAZ]) begin
            novo = (base == '0) ? base : base - SCORE_W'(1);
        end else if (cmd[CMD_MAIS3]) begin
            novo = soma_sat(base, 2'd3);
        end else if (cmd[CMD_MAIS2]) begin
            novo = soma_sat(base, 2'd2);
        end else if (cmd[CMD_MAIS1]) begin
            novo = soma_sat(base, 2'd1);
        end
        placar_a_d = placar_a_q;
        placar_b_d = placar_b_q;
        if (chave_s2_q) begin
            placar_b_d = novo;
        end else begin
            placar_a_d = novo;
        end
        if (zerar) begin
            placar_a_d = '0;
            placar_b_d = '0;
        end
        passou99_a_d = placar_a_d > SCORE_W'(LIMITE_BCD);
        passou99_b_d = placar_b_d > SCORE_W'(LIMITE_BCD);
        evento_d     = (placar_a_d != placar_a_q) || (placar_b_d != placar_b_q);
    end

    assign placar_a   = placar_a_q;
    assign placar_b   = placar_b_q;
    assign passou99_a = passou99_a_q;
    assign passou99_b = passou99_b_q;
    assign evento     = evento_q;

endmodule

// File: tb/tb_placar_entrada_botoes.sv
// Bench for placar_entrada_botoes: directed scenarios plus random key activity, all
// outputs compared each cycle against a run-length based reference model.
module tb_placar_entrada_botoes;

    localparam int unsigned D   = 4;
    localparam int unsigned W   = 8;
    localparam int          MAX = 199;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [3:0]   btn_n;
    logic         chave_time;
    logic         zerar;
    logic [W-1:0] placar_a, placar_b;
    logic         passou99_a, passou99_b, evento;

    int checks   = 0;
    int errors   = 0;
    bit ativo    = 1'b0;
    int ev_count = 0;

    always #5 clock = ~clock;

    placar_entrada_botoes #(
        .DEBOUNCE_CYCLES(D),
        .SCORE_W        (W),
        .SCORE_MAX      (MAX)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .btn_n     (btn_n),
        .chave_time(chave_time),
        .zerar     (zerar),
        .placar_a  (placar_a),
        .placar_b  (placar_b),
        .passou99_a(passou99_a),
        .passou99_b(passou99_b),
        .evento    (evento)
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, esp);
        end
    endtask

    // Reference model: a press is a run of D+1 synchronized-high samples that starts after
    // the key has been seen released; a release is a run of D+1 low samples.
    int         m_a = 0, m_b = 0;
    bit         m_p99a = 0, m_p99b = 0, m_ev = 0;
    logic [4:0] hist[$];
    bit         pressed[4];
    int         run1[4], run0[4];
    bit         armed[4];

    always @(posedge clock) begin : modelo
        logic [4:0] s;
        bit         valid;
        bit   [3:0] fire;
        int         old_a, old_b, base, novo;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                pressed[i] = 0;
                run1[i]    = 0;
                run0[i]    = 0;
                armed[i]   = 0;
            end
            hist.delete();
            m_a = 0; m_b = 0; m_p99a = 0; m_p99b = 0; m_ev = 0;
        end else begin
            valid = (hist.size() >= 2);
            s     = valid ? hist[0] : 5'b0;
            hist.push_back({chave_time, ~btn_n});
            if (hist.size() > 2) void'(hist.pop_front());
            fire = '0;
            for (int i = 0; i < 4; i++) begin
                if (!pressed[i]) begin
                    if (s[i]) begin
                        if (armed[i]) begin
                            run1[i]++;
                            if (run1[i] == D + 1) begin
                                fire[i]    = 1;
                                pressed[i] = 1;
                                run0[i]    = 0;
                            end
                        end
                    end else begin
                        run1[i] = 0;
                        if (valid) armed[i] = 1;
                    end
                end else begin
                    if (!s[i]) begin
                        run0[i]++;
                        if (run0[i] == D + 1) begin
                            pressed[i] = 0;
                            run1[i]    = 0;
                        end
                    end else begin
                        run0[i] = 0;
                    end
                end
            end
            old_a = m_a;
            old_b = m_b;
            base  = s[4] ? m_b : m_a;
            novo  = base;
            if (fire[3])      novo = (base > 0) ? base - 1 : 0;
            else if (fire[2]) novo = (base + 3 > MAX) ? MAX : base + 3;
            else if (fire[1]) novo = (base + 2 > MAX) ? MAX : base + 2;
            else if (fire[0]) novo = (base + 1 > MAX) ? MAX : base + 1;
            if (s[4]) m_b = novo;
            else      m_a = novo;
            if (zerar) begin
                m_a = 0;
                m_b = 0;
            end
            m_p99a = (m_a > 99);
            m_p99b = (m_b > 99);
            m_ev   = (m_a != old_a) || (m_b != old_b);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (ativo) begin
            verifica("placar_a", placar_a, m_a);
            verifica("placar_b", placar_b, m_b);
            verifica("passou99_a", passou99_a, m_p99a);
            verifica("passou99_b", passou99_b, m_p99b);
            verifica("evento", evento, m_ev);
            if (evento) ev_count++;
        end
    end

    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pressiona(input int k, input int hold);
        btn_n[k] = 1'b0;
        ciclos(hold);
        btn_n[k] = 1'b1;
        ciclos(12);
    endtask

    initial begin
        reset_n    = 1'b0;
        btn_n      = 4'b1011;   // +3 key held through reset
        chave_time = 1'b0;
        zerar      = 1'b0;
        ciclos(2);
        ativo = 1'b1;
        ciclos(1);
        verifica("reset_a", placar_a, 0);
        verifica("reset_b", placar_b, 0);
        verifica("reset_evento", evento, 0);
        reset_n = 1'b1;
        ciclos(20);
        verifica("held_through_reset", placar_a, 0);
        btn_n[2] = 1'b1;
        ciclos(10);
        pressiona(2, 8);
        verifica("repress_after_reset", placar_a, 3);

        // Bounce rejection
        zerar = 1'b1; ciclos(1); zerar = 1'b0; ciclos(2);
        ev_count = 0;
        btn_n[0] = 1'b0; ciclos(2);
        btn_n[0] = 1'b1; ciclos(1);
        btn_n[0] = 1'b0; ciclos(6);
        btn_n[0] = 1'b1; ciclos(12);
        verifica("bounce_a", placar_a, 1);
        verifica("bounce_b", placar_b, 0);
        verifica("bounce_eventos", ev_count, 1);

        // Team B adds
        chave_time = 1'b1; ciclos(4);
        pressiona(2, 8);
        pressiona(1, 8);
        pressiona(2, 8);
        verifica("team_b", placar_b, 8);
        verifica("team_b_a_kept", placar_a, 1);

        // Saturation on team A
        chave_time = 1'b0;
        zerar = 1'b1; ciclos(1); zerar = 1'b0; ciclos(3);
        for (int n = 0; n < 66; n++) pressiona(2, 8);
        verifica("sat_198", placar_a, 198);
        pressiona(0, 8);
        verifica("sat_199", placar_a, 199);
        ev_count = 0;
        pressiona(2, 8);
        verifica("sat_hold", placar_a, 199);
        verifica("sat_p99", passou99_a, 1);
        verifica("sat_no_evento", ev_count, 0);
        zerar = 1'b1; ciclos(1); zerar = 1'b0; ciclos(3);
        ev_count = 0;
        pressiona(3, 8);
        verifica("undo_at_zero", placar_a, 0);
        verifica("undo_zero_no_evento", ev_count, 0);

        // Simultaneous commands
        pressiona(2, 8);
        pressiona(1, 8);
        verifica("five", placar_a, 5);
        btn_n = 4'b0101;
        ciclos(8);
        btn_n = 4'b1111;
        ciclos(12);
        verifica("undo_beats_add", placar_a, 4);
        btn_n[0] = 1'b0;
        ciclos(6);
        zerar = 1'b1; ciclos(1); zerar = 1'b0;
        ciclos(2);
        btn_n[0] = 1'b1;
        ciclos(12);
        verifica("zerar_beats_add_a", placar_a, 0);
        verifica("zerar_beats_add_b", placar_b, 0);

        // Long hold, no auto-repeat
        btn_n[1] = 1'b0;
        ciclos(50);
        btn_n[1] = 1'b1;
        ciclos(12);
        verifica("hold_once", placar_a, 2);
        pressiona(1, 8);
        verifica("hold_second", placar_a, 4);

        // Random key activity, switch flips, clears and resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) btn_n[i] = ~btn_n[i];
            end
            if ($urandom_range(39) == 0) chave_time = ~chave_time;
            zerar   = ($urandom_range(127) == 0);
            reset_n = ($urandom_range(399) != 0);
            ciclos(1);
        end
        reset_n = 1'b1;
        zerar   = 1'b0;
        ciclos(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
